// File: rtl/sync_fifo_param.sv
// Synchronous single-clock FIFO with registered read data, occupancy count,
// threshold flags and sticky overflow/underflow error flags.
// All DEPTH entries are usable; the count register, not the pointers,
// is what distinguishes full from empty.
module sync_fifo_param #(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 8,
  parameter int AFULL_LVL  = 6,
  parameter int AEMPTY_LVL = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       data_1_en,
  input  logic [WIDTH-1:0]           data_1,
  input  logic                       rd_en,
  input  logic                       clr_err,
  output logic [WIDTH-1:0]           data_2,
  output logic                       data_valid_2,
  output logic                       buffer_empty,
  output logic                       buffer_full,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] FULL_C   = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_LVL);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_LVL);

  // Storage has no reset so it can map onto block RAM.
  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] data_2_q, data_2_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;

  logic             empty_w;
  logic             full_w;
  logic             wr_acc;
  logic             rd_acc;

  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == FULL_C);

  // A full FIFO rejects writes and an empty one rejects reads, regardless
  // of what the other port does in the same cycle (no fall-through).
  assign wr_acc = data_1_en & ~full_w;
  assign rd_acc = rd_en & ~empty_w;

  // Next-state logic for pointers, count, read register and error flags.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    data_2_d = data_2_q;
    valid_d  = 1'b0;

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      data_2_d = mem[rd_ptr_q];
      valid_d  = 1'b1;
    end

    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Setting takes precedence over a coincident clear.
    ovf_d = (ovf_q & ~clr_err) | (data_1_en & full_w);
    udf_d = (udf_q & ~clr_err) | (rd_en & empty_w);
  end

  // Storage write port.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr_q] <= data_1;
    end
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      data_2_q <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      data_2_q <= data_2_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  assign data_2       = data_2_q;
  assign data_valid_2 = valid_q;
  assign count        = count_q;
  assign buffer_empty = empty_w;
  assign buffer_full  = full_w;
  assign almost_full  = (count_q >= AFULL_C);
  assign almost_empty = (count_q <= AEMPTY_C);
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule
